muxnx1_tdm: RTL and testbench

Parametrised N-channel registered multiplexer. It is the successor of the 2:1 combinational mux. Manual mode is a registered N:1 select. Auto mode time-division scans the channels with a programmable dwell and can optionally skip idle channels. It sits between parallel data sources and a single shared downstream sink.

---
 rtl/muxnx1_tdm_if.sv | 25 ++
 rtl/muxnx1_tdm.sv | 104 ++++++++++
 tb/tb_muxnx1_tdm.sv | 121 ++++++++++++
 3 files changed

// File: rtl/muxnx1_tdm_if.sv
// rtl/muxnx1_tdm_if.sv - channel/data bundle between sources, the TDM mux and its sink
interface muxnx1_tdm_if #(
    parameter int N_CH = 4,
    parameter int W    = 8,
    parameter int SW   = $clog2(N_CH)
);
    logic [N_CH*W-1:0] i_data;
    logic [N_CH-1:0]   i_valid;
    logic [SW-1:0]     sel;
    logic              mode;
    logic              skip_idle;
    logic [W-1:0]      Y;
    logic              y_valid;
    logic [SW-1:0]     y_ch;

    modport master (
        output i_data, i_valid, sel, mode, skip_idle,
        input  Y, y_valid, y_ch
    );

    modport slave (
        input  i_data, i_valid, sel, mode, skip_idle,
        output Y, y_valid, y_ch
    );
endinterface

// File: rtl/muxnx1_tdm.sv
// rtl/muxnx1_tdm.sv - registered N:1 mux with manual select and dwell-based TDM scan
module muxnx1_tdm #(
    parameter int N_CH  = 4,
    parameter int W     = 8,
    parameter int DWELL = 4
) (
    input logic          clk,
    input logic          rst,
    muxnx1_tdm_if.slave  bus
);
    localparam int SW = $clog2(N_CH);
    localparam int CW = (DWELL > 1) ? $clog2(DWELL) : 1;

    logic [SW-1:0] ptr;
    logic [CW-1:0] cnt;
    logic [W-1:0]  y_q;
    logic          y_valid_q;
    logic [SW-1:0] y_ch_q;

    logic [SW-1:0] cur;
    logic          sel_ok;
    logic [W-1:0]  sel_data;
    logic          sel_valid;
    logic [W-1:0]  cur_data;
    logic          cur_valid;
    logic [SW-1:0] nxt_wrap;
    logic [SW-1:0] nxt_skip;

    // Decode the manual select and the scan pointer; a pointer left out of range
    // by manual mode is treated as channel 0 so the scan restarts cleanly.
    always_comb begin
        logic [N_CH*W-1:0] d_sh;
        logic [N_CH-1:0]   v_sh;
        sel_ok    = int'(bus.sel) < N_CH;
        d_sh      = bus.i_data >> (int'(bus.sel) * W);
        v_sh      = bus.i_valid >> int'(bus.sel);
        sel_data  = d_sh[W-1:0];
        sel_valid = v_sh[0];
        cur       = (int'(ptr) < N_CH) ? ptr : '0;
        d_sh      = bus.i_data >> (int'(cur) * W);
        v_sh      = bus.i_valid >> int'(cur);
        cur_data  = d_sh[W-1:0];
        cur_valid = v_sh[0];
    end

    // Next channel on an advance: plain round-robin, or first valid channel after
    // the current one (the last candidate is the current channel itself).
    always_comb begin
        int            idx;
        logic          found;
        logic [N_CH-1:0] v_sh;
        idx      = int'(cur) + 1;
        if (idx >= N_CH) idx = 0;
        nxt_wrap = SW'(idx);
        nxt_skip = nxt_wrap;
        found    = 1'b0;
        for (int j = 1; j <= N_CH; j++) begin
            idx = int'(cur) + j;
            if (idx >= N_CH) idx = idx - N_CH;
            v_sh = bus.i_valid >> idx;
            if (!found && v_sh[0]) begin
                found    = 1'b1;
                nxt_skip = SW'(idx);
            end
        end
    end

    // Output registers plus scan pointer/dwell counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            cnt       <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            y_ch_q    <= '0;
        end else if (!bus.mode) begin
            ptr    <= bus.sel;
            cnt    <= '0;
            y_ch_q <= bus.sel;
            if (sel_ok) begin
                y_q       <= sel_data;
                y_valid_q <= sel_valid;
            end else begin
                y_q       <= '0;
                y_valid_q <= 1'b0;
            end
        end else begin
            y_q       <= cur_data;
            y_valid_q <= cur_valid;
            y_ch_q    <= cur;
            if (cnt == CW'(DWELL - 1)) begin
                cnt <= '0;
                ptr <= bus.skip_idle ? nxt_skip : nxt_wrap;
            end else begin
                cnt <= cnt + 1'b1;
                ptr <= cur;
            end
        end
    end

    assign bus.Y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.y_ch    = y_ch_q;
endmodule

// File: tb/tb_muxnx1_tdm.sv
// tb/tb_muxnx1_tdm.sv - directed self-checking bench for muxnx1_tdm
module tb_muxnx1_tdm;
    logic clk = 1'b0;
    logic rst4;
    logic rst3;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    muxnx1_tdm_if #(.N_CH(4), .W(8)) bus4 ();
    muxnx1_tdm_if #(.N_CH(3), .W(8)) bus3 ();

    muxnx1_tdm #(.N_CH(4), .W(8), .DWELL(4)) dut4 (.clk(clk), .rst(rst4), .bus(bus4));
    muxnx1_tdm #(.N_CH(3), .W(8), .DWELL(4)) dut3 (.clk(clk), .rst(rst3), .bus(bus3));

    logic [7:0] dat [4];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int ch;
        int seq [4];
        dat[0] = 8'h11; dat[1] = 8'h22; dat[2] = 8'hA5; dat[3] = 8'h44;

        // Test 1: reset with every input non-zero
        rst4 = 1'b1; rst3 = 1'b1;
        bus4.i_data = {8'h44, 8'hA5, 8'h22, 8'h11};
        bus4.i_valid = 4'b1111; bus4.sel = 2'd3; bus4.mode = 1'b1; bus4.skip_idle = 1'b1;
        bus3.i_data = {8'hA5, 8'h22, 8'h11};
        bus3.i_valid = 3'b111; bus3.sel = 2'd0; bus3.mode = 1'b0; bus3.skip_idle = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_y", 32'(bus4.Y), 32'h0);
            check("rst_v", 32'(bus4.y_valid), 32'h0);
            check("rst_ch", 32'(bus4.y_ch), 32'h0);
        end

        // Test 2: manual select with one cycle of lag
        rst4 = 1'b0; bus4.mode = 1'b0; bus4.skip_idle = 1'b0; bus4.sel = 2'd2;
        step();
        check("man2_y", 32'(bus4.Y), 32'hA5);
        check("man2_v", 32'(bus4.y_valid), 32'h1);
        check("man2_ch", 32'(bus4.y_ch), 32'h2);
        seq = '{0, 1, 3, 3};
        for (int i = 0; i < 3; i++) begin
            bus4.sel = 2'(seq[i]);
            step();
            check("man_y", 32'(bus4.Y), 32'(dat[seq[i]]));
            check("man_ch", 32'(bus4.y_ch), 32'(seq[i]));
        end

        // Test 3: auto scan, no skip, wraps 3 -> 0
        rst4 = 1'b1; step();
        rst4 = 1'b0; bus4.mode = 1'b1; bus4.skip_idle = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            ch = (k / 4) % 4;
            check("auto_ch", 32'(bus4.y_ch), 32'(ch));
            check("auto_y", 32'(bus4.Y), 32'(dat[ch]));
            check("auto_v", 32'(bus4.y_valid), 32'h1);
        end

        // Test 4: skip idle channels with only ch1/ch3 valid
        rst4 = 1'b1; step();
        rst4 = 1'b0; bus4.i_valid = 4'b1010; bus4.skip_idle = 1'b1;
        seq = '{0, 1, 3, 1};
        for (int k = 0; k < 16; k++) begin
            step();
            ch = seq[k / 4];
            check("skip_ch", 32'(bus4.y_ch), 32'(ch));
            check("skip_y", 32'(bus4.Y), 32'(dat[ch]));
            check("skip_v", 32'(bus4.y_valid), (k < 4) ? 32'h0 : 32'h1);
        end

        // Test 5: reset in the middle of channel 2's dwell
        rst4 = 1'b1; step();
        rst4 = 1'b0; bus4.i_valid = 4'b1111; bus4.skip_idle = 1'b0;
        for (int k = 0; k < 10; k++) step();
        check("mid_ch_before", 32'(bus4.y_ch), 32'h2);
        rst4 = 1'b1; step();
        check("mid_rst_y", 32'(bus4.Y), 32'h0);
        check("mid_rst_v", 32'(bus4.y_valid), 32'h0);
        check("mid_rst_ch", 32'(bus4.y_ch), 32'h0);
        rst4 = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            check("mid_restart_ch", 32'(bus4.y_ch), 32'h0);
        end
        step();
        check("mid_next_ch", 32'(bus4.y_ch), 32'h1);

        // Test 6: three channels, out-of-range select, then scan wrap 2 -> 0
        rst3 = 1'b0; bus3.mode = 1'b0; bus3.sel = 2'd3;
        step();
        check("np2_oor_y", 32'(bus3.Y), 32'h0);
        check("np2_oor_v", 32'(bus3.y_valid), 32'h0);
        check("np2_oor_ch", 32'(bus3.y_ch), 32'h3);
        bus3.mode = 1'b1;
        for (int k = 0; k < 16; k++) begin
            step();
            ch = (k / 4) % 3;
            check("np2_ch", 32'(bus3.y_ch), 32'(ch));
            check("np2_y", 32'(bus3.Y), 32'(dat[ch]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
